// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan reader: segment patterns,
// FSM state encoding and the decoded-digit record.
package seven_seg_pkg;

    // Segment patterns on seg[7:1] = {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    typedef enum logic {
        WAIT_STABLE = 1'b0,
        HOLD        = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] digit;
        logic       dp;
        logic       invalid;
    } dec_digit_t;

endpackage

// File: rtl/seven_seg_decode.sv
// Single-digit seven-segment decoder (purely combinational).
// Unknown patterns decode to digit 0 with the invalid flag raised; the
// decimal point passes through regardless of validity.
module seven_seg_decode
    import seven_seg_pkg::*;
#(
    parameter int HEX_EN = 1
) (
    input  logic [7:0]  i_seg,
    output dec_digit_t  o_dec
);

    localparam bit HEX_ON = (HEX_EN != 0);

    // Map the seven segment lines to a digit value
    always_comb begin
        o_dec.digit   = 4'd0;
        o_dec.dp      = i_seg[0];
        o_dec.invalid = 1'b0;
        case (i_seg[7:1])
            SEG_0: o_dec.digit = 4'h0;
            SEG_1: o_dec.digit = 4'h1;
            SEG_2: o_dec.digit = 4'h2;
            SEG_3: o_dec.digit = 4'h3;
            SEG_4: o_dec.digit = 4'h4;
            SEG_5: o_dec.digit = 4'h5;
            SEG_6: o_dec.digit = 4'h6;
            SEG_7: o_dec.digit = 4'h7;
            SEG_8: o_dec.digit = 4'h8;
            SEG_9: o_dec.digit = 4'h9;
            SEG_A: if (HEX_ON) o_dec.digit = 4'hA; else o_dec.invalid = 1'b1;
            SEG_B: if (HEX_ON) o_dec.digit = 4'hB; else o_dec.invalid = 1'b1;
            SEG_C: if (HEX_ON) o_dec.digit = 4'hC; else o_dec.invalid = 1'b1;
            SEG_D: if (HEX_ON) o_dec.digit = 4'hD; else o_dec.invalid = 1'b1;
            SEG_E: if (HEX_ON) o_dec.digit = 4'hE; else o_dec.invalid = 1'b1;
            SEG_F: if (HEX_ON) o_dec.digit = 4'hF; else o_dec.invalid = 1'b1;
            default: o_dec.invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// Rebuilds a full multiplexed seven-segment frame from the shared segment
// bus and anode lines. A pattern is captured once it has been stable for
// STABLE_CYCLES samples; a snapshot is published when every digit is in.
module seven_seg_scan_reader
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int STABLE_CYCLES  = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0,
    parameter int HEX_EN         = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   invalid_out,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]            SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_INV   = (AN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] ALL_DIGS = '1;

    // Input samples (raw pin polarity) and the sample before them
    logic [7:0]            r_s_seg, r_p_seg;
    logic [NUM_DIGITS-1:0] r_s_an,  r_p_an;

    state_t                r_state, w_state_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic [NUM_DIGITS-1:0] r_captured, w_captured_next;
    dec_digit_t            r_shadow [NUM_DIGITS];

    logic [7:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_an, w_mask, w_write;
    logic                  w_chg, w_blank, w_onehot, w_multi;
    logic                  w_complete, w_capture, w_err;
    dec_digit_t            w_dec;

    logic [4*NUM_DIGITS-1:0] w_shadow_digits;
    logic [NUM_DIGITS-1:0]   w_shadow_dp, w_shadow_inv;

    assign w_seg    = r_s_seg ^ SEG_INV;
    assign w_an     = r_s_an ^ AN_INV;
    assign w_chg    = (r_s_seg != r_p_seg) || (r_s_an != r_p_an);
    assign w_blank  = (w_an == '0);
    assign w_onehot = !w_blank && ((w_an & (w_an - NUM_DIGITS'(1))) == '0);
    assign w_multi  = !w_blank && !w_onehot;

    // A full mask is published this cycle; treat it as already empty so a
    // simultaneous capture lands in the next frame.
    assign w_complete = (r_captured == ALL_DIGS);
    assign w_mask     = w_complete ? '0 : r_captured;

    seven_seg_decode #(
        .HEX_EN (HEX_EN)
    ) u_decode (
        .i_seg (w_seg),
        .o_dec (w_dec)
    );

    // Flatten the shadow registers into the published bus layout
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_flat
        assign w_shadow_digits[4*gi +: 4] = r_shadow[gi].digit;
        assign w_shadow_dp[gi]            = r_shadow[gi].dp;
        assign w_shadow_inv[gi]           = r_shadow[gi].invalid;
    end

    // Register the pins once and keep the previous sample for change detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s_seg <= '0;
            r_s_an  <= '0;
            r_p_seg <= '0;
            r_p_an  <= '0;
        end else begin
            r_s_seg <= seg_in;
            r_s_an  <= an_in;
            r_p_seg <= r_s_seg;
            r_p_an  <= r_s_an;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= WAIT_STABLE;
        else        r_state <= w_state_next;
    end

    // FSM next state: leave WAIT on a qualified capture, leave HOLD on change
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_STABLE: if (w_onehot && !w_chg && r_cnt == CNT_MAX) w_state_next = HOLD;
            HOLD:        if (w_chg) w_state_next = WAIT_STABLE;
            default:     w_state_next = WAIT_STABLE;
        endcase
    end

    // FSM outputs: dwell counter, capture request, error and mask update
    always_comb begin
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        w_err      = w_multi && w_chg;
        case (r_state)
            WAIT_STABLE: begin
                if (w_multi || w_chg || w_blank) w_cnt_next = '0;
                else if (r_cnt == CNT_MAX)       w_capture  = 1'b1;
                else                             w_cnt_next = r_cnt + CNT_W'(1);
            end
            HOLD: if (w_chg) w_cnt_next = '0;
            default: w_cnt_next = '0;
        endcase
        // First capture of a digit within a frame wins
        w_write         = w_capture ? (w_an & ~w_mask) : '0;
        w_captured_next = w_err ? '0 : (w_mask | w_write);
    end

    // Datapath: counter, capture mask, shadow writes and frame publication
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_captured  <= '0;
            digits_out  <= '0;
            dp_out      <= '0;
            invalid_out <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= '0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_captured  <= w_captured_next;
            frame_valid <= w_complete;
            frame_err   <= w_err;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_write[i]) r_shadow[i] <= w_dec;
            end
            if (w_complete) begin
                digits_out  <= w_shadow_digits;
                dp_out      <= w_shadow_dp;
                invalid_out <= w_shadow_inv;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Bench for seven_seg_scan_reader: a hex-mode active-high instance and a
// decimal-only active-low instance driven by the same logical stimulus.
module tb_seven_seg_scan_reader;

    localparam int ND = 6;
    localparam int SC = 4;

    localparam logic [6:0] PAT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct packed {
        logic [4*ND-1:0] dig;
        logic [ND-1:0]   dp;
        logic [ND-1:0]   inv;
    } frame_t;

    typedef struct packed {
        logic [8*ND-1:0] segs;      // digit d pattern at [8d+:8]
        logic [4*ND-1:0] dig_hex;
        logic [4*ND-1:0] dig_dec;
        logic [ND-1:0]   dp;
        logic [ND-1:0]   inv_hex;
        logic [ND-1:0]   inv_dec;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n = 1'b0;
    logic [7:0]      seg_l = '0;
    logic [ND-1:0]   an_l  = '0;
    logic [7:0]      seg_n;
    logic [ND-1:0]   an_n;
    assign seg_n = ~seg_l;
    assign an_n  = ~an_l;

    logic [4*ND-1:0] digits_a, digits_b;
    logic [ND-1:0]   dp_a, dp_b, inv_a, inv_b;
    logic            fv_a, fv_b, err_a, err_b;

    seven_seg_scan_reader #(
        .NUM_DIGITS(ND), .STABLE_CYCLES(SC),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .HEX_EN(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_l), .an_in(an_l),
        .digits_out(digits_a), .dp_out(dp_a), .invalid_out(inv_a),
        .frame_valid(fv_a), .frame_err(err_a)
    );

    seven_seg_scan_reader #(
        .NUM_DIGITS(ND), .STABLE_CYCLES(SC),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .HEX_EN(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_n), .an_in(an_n),
        .digits_out(digits_b), .dp_out(dp_b), .invalid_out(inv_b),
        .frame_valid(fv_b), .frame_err(err_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (run-length based) ----------------
    logic [7:0]    m_prev_seg [2];
    logic [ND-1:0] m_prev_an  [2];
    int            m_run      [2];
    logic [ND-1:0] m_mask     [2];
    logic [3:0]    m_dig      [2][ND];
    logic          m_dp       [2][ND];
    logic          m_inv      [2][ND];
    frame_t        m_last     [2];
    int            m_err      [2];
    frame_t        q0 [$];
    frame_t        q1 [$];
    int            obs_fv     [2];
    int            obs_err    [2];

    function automatic void ref_decode(input logic [7:0] s, input bit hex,
                                       output logic [3:0] d, output logic p, output logic inv);
        d = 4'd0;
        p = s[0];
        inv = 1'b1;
        for (int v = 0; v < 16; v++) begin
            if (s[7:1] == PAT[v] && (v < 10 || hex)) begin
                d = v[3:0];
                inv = 1'b0;
            end
        end
    endfunction

    task automatic model_reset(input int m);
        // after reset the sample registers hold raw zeros
        m_prev_seg[m] = (m == 0) ? 8'h00 : 8'hFF;
        m_prev_an[m]  = (m == 0) ? '0 : '1;
        m_run[m]  = 1;
        m_mask[m] = '0;
        m_last[m] = '0;
        for (int d = 0; d < ND; d++) begin
            m_dig[m][d] = '0;
            m_dp[m][d]  = 1'b0;
            m_inv[m][d] = 1'b0;
        end
    endtask

    // A capture happens when a one-hot value has been seen SC+1 samples in a row
    task automatic model_step(input int m, input logic [7:0] s, input logic [ND-1:0] a);
        int ones;
        int k;
        frame_t f;
        if (s == m_prev_seg[m] && a == m_prev_an[m]) begin
            if (m_run[m] < 1000) m_run[m]++;
        end else begin
            m_run[m] = 1;
            m_prev_seg[m] = s;
            m_prev_an[m]  = a;
        end
        ones = $countones(a);
        if (ones > 1 && m_run[m] == 1) begin
            m_err[m]++;
            m_mask[m] = '0;
        end
        if (ones == 1 && m_run[m] == SC + 1) begin
            k = 0;
            for (int d = 0; d < ND; d++) if (a[d]) k = d;
            if (!m_mask[m][k]) begin
                ref_decode(s, (m == 0), m_dig[m][k], m_dp[m][k], m_inv[m][k]);
                m_mask[m][k] = 1'b1;
            end
            if (&m_mask[m]) begin
                for (int d = 0; d < ND; d++) begin
                    f.dig[4*d +: 4] = m_dig[m][d];
                    f.dp[d]         = m_dp[m][d];
                    f.inv[d]        = m_inv[m][d];
                end
                m_last[m] = f;
                m_mask[m] = '0;
                if (m == 0) q0.push_back(f); else q1.push_back(f);
            end
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        frame_t f;
        if (rst_n) begin
            if (err_a) obs_err[0]++;
            if (fv_a) begin
                obs_fv[0]++;
                chk("frame_a queued", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) begin
                    f = q0.pop_front();
                    chk("frame_a digits", 64'(digits_a), 64'(f.dig));
                    chk("frame_a dp",     64'(dp_a),     64'(f.dp));
                    chk("frame_a invalid",64'(inv_a),    64'(f.inv));
                    $display("frame inst_a #%0d: digits=%h dp=%b invalid=%b", obs_fv[0], digits_a, dp_a, inv_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        frame_t f;
        if (rst_n) begin
            if (err_b) obs_err[1]++;
            if (fv_b) begin
                obs_fv[1]++;
                chk("frame_b queued", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) begin
                    f = q1.pop_front();
                    chk("frame_b digits", 64'(digits_b), 64'(f.dig));
                    chk("frame_b dp",     64'(dp_b),     64'(f.dp));
                    chk("frame_b invalid",64'(inv_b),    64'(f.inv));
                    $display("frame inst_b #%0d: digits=%h dp=%b invalid=%b", obs_fv[1], digits_b, dp_b, inv_b);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [7:0] s, input logic [ND-1:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            seg_l = s;
            an_l  = a;
            @(posedge clk);
            #1;
            model_step(0, s, a);
            model_step(1, s, a);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        seg_l = '0;
        an_l  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset(0);
        model_reset(1);
    endtask

    task automatic scan(input logic [8*ND-1:0] segs);
        for (int d = 0; d < ND; d++) drive(segs[8*d +: 8], ND'(1) << d, 8);
        drive(8'h00, '0, 6);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " digits_a"}, 64'(digits_a), 64'd0);
        chk({tag, " dp_a"},     64'(dp_a),     64'd0);
        chk({tag, " inv_a"},    64'(inv_a),    64'd0);
        chk({tag, " fv_a"},     64'(fv_a),     64'd0);
        chk({tag, " err_a"},    64'(err_a),    64'd0);
        chk({tag, " digits_b"}, 64'(digits_b), 64'd0);
        chk({tag, " inv_b"},    64'(inv_b),    64'd0);
        chk({tag, " fv_b"},     64'(fv_b),     64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [3];
        int f0, f1, e0, e1, last_k;

        tbl[0] = '{segs: 48'hB7_66_F2_DA_60_FC, dig_hex: 24'h543210, dig_dec: 24'h543210,
                   dp: 6'b100000, inv_hex: 6'b000000, inv_dec: 6'b000000};
        tbl[1] = '{segs: 48'h8F_7A_9C_3E_EE_02, dig_hex: 24'hFDCBA0, dig_dec: 24'h000000,
                   dp: 6'b100000, inv_hex: 6'b000001, inv_dec: 6'b111111};
        tbl[2] = '{segs: 48'h9E_BE_E0_E6_FF_FE, dig_hex: 24'hE67088, dig_dec: 24'h067088,
                   dp: 6'b000010, inv_hex: 6'b000100, inv_dec: 6'b100100};

        for (int m = 0; m < 2; m++) begin
            m_err[m] = 0; obs_fv[m] = 0; obs_err[m] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk_zero("reset");

        // Table-driven complete frames (active-high hex vs active-low decimal)
        for (int i = 0; i < 3; i++) begin
            f0 = obs_fv[0]; f1 = obs_fv[1];
            scan(tbl[i].segs);
            chk("tbl frames_a", 64'(obs_fv[0] - f0), 64'd1);
            chk("tbl frames_b", 64'(obs_fv[1] - f1), 64'd1);
            chk("tbl digits_a", 64'(digits_a), 64'(tbl[i].dig_hex));
            chk("tbl dp_a",     64'(dp_a),     64'(tbl[i].dp));
            chk("tbl inv_a",    64'(inv_a),    64'(tbl[i].inv_hex));
            chk("tbl digits_b", 64'(digits_b), 64'(tbl[i].dig_dec));
            chk("tbl dp_b",     64'(dp_b),     64'(tbl[i].dp));
            chk("tbl inv_b",    64'(inv_b),    64'(tbl[i].inv_dec));
        end

        // Glitch: digit 2 briefly shows an 8 before settling on 2
        f0 = obs_fv[0];
        drive(8'hFC, 6'b000001, 8);
        drive(8'h60, 6'b000010, 8);
        drive(8'hFE, 6'b000100, 2);
        drive(8'hDA, 6'b000100, 8);
        drive(8'hF2, 6'b001000, 8);
        drive(8'h66, 6'b010000, 8);
        drive(8'hB7, 6'b100000, 8);
        drive(8'h00, '0, 6);
        chk("glitch frames_a", 64'(obs_fv[0] - f0), 64'd1);
        chk("glitch digits_a", 64'(digits_a), 64'h543210);

        // Multi-hot anode mid-frame: error pulse, no frame, outputs held
        f0 = obs_fv[0]; e0 = obs_err[0]; e1 = obs_err[1];
        drive(8'h9C, 6'b000001, 8);
        drive(8'h7A, 6'b000010, 8);
        drive(8'hFC, 6'b000011, 8);
        drive(8'h00, '0, 6);
        chk("multi err_a",    64'(obs_err[0] - e0), 64'd1);
        chk("multi err_b",    64'(obs_err[1] - e1), 64'd1);
        chk("multi frames_a", 64'(obs_fv[0] - f0), 64'd0);
        chk("multi held_a",   64'(digits_a), 64'h543210);
        scan(tbl[1].segs);
        chk("multi next_a",   64'(digits_a), 64'hFDCBA0);

        // Reset after three digits, then a frame needs all six again
        drive(8'hFC, 6'b000001, 8);
        drive(8'h60, 6'b000010, 8);
        drive(8'hDA, 6'b000100, 8);
        drive(8'h00, '0, 3);
        do_reset();
        chk_zero("midreset");
        f0 = obs_fv[0];
        drive(8'hF2, 6'b001000, 8);
        drive(8'h66, 6'b010000, 8);
        drive(8'hB7, 6'b100000, 8);
        drive(8'h00, '0, 6);
        chk("partial frames_a", 64'(obs_fv[0] - f0), 64'd0);
        drive(8'hFC, 6'b000001, 8);
        drive(8'h60, 6'b000010, 8);
        drive(8'hDA, 6'b000010, 8);   // repeat of digit 1 must not overwrite
        drive(8'hDA, 6'b000100, 8);
        drive(8'h00, '0, 6);
        chk("repeat frames_a", 64'(obs_fv[0] - f0), 64'd1);
        chk("repeat digits_a", 64'(digits_a), 64'h543210);
        chk("repeat digits_b", 64'(digits_b), 64'h543210);

        // Randomised scanning checked against the model via the monitors
        last_k = 0;
        for (int i = 0; i < 400; i++) begin
            int r, ra, x, y, len;
            logic [7:0] s;
            logic [ND-1:0] a;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive(8'h00, '0, 10);
                chk("pre-reset drain_a", 64'(q0.size()), 64'd0);
                do_reset();
            end else begin
                if ($urandom_range(0, 99) < 75)
                    s = {PAT[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
                else
                    s = 8'($urandom);
                ra = $urandom_range(0, 99);
                if (ra < 8) begin
                    a = '0;
                end else if (ra < 18) begin
                    x = $urandom_range(0, ND - 1);
                    y = (x + 1 + $urandom_range(0, ND - 2)) % ND;
                    a = (ND'(1) << x) | (ND'(1) << y);
                end else begin
                    if ($urandom_range(0, 9) < 7) last_k = (last_k + 1) % ND;
                    else                          last_k = $urandom_range(0, ND - 1);
                    a = ND'(1) << last_k;
                end
                len = ($urandom_range(0, 1) != 0) ? $urandom_range(SC + 1, SC + 6)
                                                  : $urandom_range(1, SC + 1);
                drive(s, a, len);
            end
        end
        drive(8'h00, '0, 12);

        chk("final queue_a",  64'(q0.size()), 64'd0);
        chk("final queue_b",  64'(q1.size()), 64'd0);
        chk("final errs_a",   64'(obs_err[0]), 64'(m_err[0]));
        chk("final errs_b",   64'(obs_err[1]), 64'(m_err[1]));
        chk("final digits_a", 64'(digits_a), 64'(m_last[0].dig));
        chk("final inv_a",    64'(inv_a),    64'(m_last[0].inv));
        chk("final digits_b", 64'(digits_b), 64'(m_last[1].dig));
        chk("final dp_b",     64'(dp_b),     64'(m_last[1].dp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_reader.md
Name: seven_seg_scan_reader

Overview:
Reconstructs a full multiplexed N-digit seven-segment display frame from the shared segment bus and the anode-select lines.
- Each segment pattern is accepted only after it has been stable for a dwell threshold.
- Each accepted pattern is decoded to a 4-bit digit, a decimal-point flag and an invalid flag.
- The block publishes a coherent snapshot with a one-cycle strobe once every digit has been captured.
- It sits between the display-driver outputs and the stopwatch/timer checker or logic-analyser path.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digits (anode lines); range 1..16.
- STABLE_CYCLES, 4, consecutive identical samples required before capture; must be ≥1.
- SEG_ACTIVE_LOW, 0, 1 means seg_in is inverted before decoding.
- AN_ACTIVE_LOW, 0, 1 means an_in is inverted before use.
- HEX_EN, 1, 0 means the A–F patterns are flagged invalid (decimal-only mode).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- seg_in  in  8  segment bus: [7]=a … [1]=g, [0]=dp
- an_in  in  NUM_DIGITS  anode select; bit i = digit i
- digits_out  out  4*NUM_DIGITS  decoded digits; digit i at [4i+3:4i]
- dp_out  out  NUM_DIGITS  decimal-point flags
- invalid_out  out  NUM_DIGITS  per-digit invalid-pattern flags
- frame_valid  out  1  one-cycle pulse; outputs updated this cycle
- frame_err  out  1  one-cycle pulse; multi-hot anode seen, partial frame discarded

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - digits_out, dp_out, invalid_out, frame_valid, frame_err;
  - captured mask, shadow registers, stability counter, sample registers;
  - FSM → WAIT_STABLE.
  - Reset mid-frame discards all partial captures.
- Input stage: seg_in/an_in are registered once (s_seg, s_an), then polarity-normalised. All following logic uses the registered values.
- Change detect: chg = (s_seg,s_an) differs from the previous registered sample.
- Anode classes:
  - zero = blanking;
  - one-hot = valid digit index k;
  - multi-hot = error.
- FSM WAIT_STABLE:
  - On chg, or blanking: cnt←0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES-1.
  - When cnt==STABLE_CYCLES-1, anode one-hot, and !chg:
    - capture the decoded pattern into shadow[k] only if captured[k]==0;
    - set captured[k];
    - go to HOLD.
  - If captured[k] was already 1, go to HOLD without a write (first capture wins).
- FSM HOLD: stay until chg; then cnt←0 and go to WAIT_STABLE. This ensures one capture per dwell.
- STABLE_CYCLES=1 means capture on the first sample after a change. Timing is counted from the registered sample.
- Frame completion:
  - The cycle after captured becomes all-ones: digits_out/dp_out/invalid_out ← shadow, frame_valid=1 for exactly one cycle, captured←0.
  - A capture in that same cycle goes into the new frame's mask.
- Multi-hot anode on a registered sample:
  - frame_err=1 for one cycle (again on each new multi-hot sample);
  - captured←0, cnt←0, FSM→WAIT_STABLE;
  - outputs hold their last published frame.
- Decode per digit: the 16 patterns on seg[7:1]:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - Any other pattern: digit 0, invalid=1.
  - HEX_EN=0: A–F give digit 0, invalid=1.
  - dp = seg[0], independent of the invalid flag.
- Outputs change only on frame_valid or reset. They are registered with no combinational input→output path.
- Minimum latency: the last digit is published 1 (input reg) + STABLE_CYCLES + 1 cycles after its pattern first appears on the pins.

Decomposition:
- Package seven_seg_pkg holds:
  - the 7-bit segment pattern constants SEG_0..SEG_F;
  - the FSM state enum (WAIT_STABLE, HOLD);
  - a typedef for the decoded digit struct {digit[3:0], dp, invalid}.
- Sub-module seven_seg_decode: purely combinational single-digit decoder with parameter HEX_EN. It is instantiated once on the registered sample; shadow stores its output.

Test Plan:
- Complete frame: NUM_DIGITS=6, STABLE_CYCLES=4, each anode one-hot for 8 cycles with patterns 0xFC,0x60,0xDA,0xF2,0x66,0xB7 → one frame_valid pulse, digits_out=0x543210, dp_out=6'b100000, invalid_out=0.
- Glitch rejection: digit 2 shows 0xFE for 2 cycles, then 0xDA for 8 → digit 2 captured as 2, never 8.
- Invalid and mode: pattern 0x02 on digit 0 → invalid_out[0]=1, digit 0; with HEX_EN=0, 0xEE (A) → invalid=1; with HEX_EN=1 → digit A, invalid=0.
- Multi-hot anode: an_in=6'b000011 mid-frame → frame_err pulse, no frame_valid, previous outputs held; the next complete scan publishes normally.
- Polarity: SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, inverted stimulus of the first scenario → identical outputs.
- Reset mid-frame and repeat: rst_n low for 1 cycle after 3 digits → all outputs 0. The next frame requires all 6 digits. Repeating digit 1 twice in one frame keeps the first value.
